// File: rtl/aes_pkg.sv
// Shared types and constants for the AES128 request arbiter and its neighbours.
// No logic lives here; the FSM encoding and the job layout are the contract.
package aes_pkg;

   localparam int AES_BLK_W       = 128;
   localparam int AES_TIMEOUT_DEF = 64;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      BUSY,
      RESP
   } arb_state_t;

   typedef struct packed {
      logic [AES_BLK_W-1:0] key;
      logic [AES_BLK_W-1:0] pt;
   } aes_job_t;

endpackage

// File: rtl/aes_req_arbiter_if.sv
// Bundle of requester, response and AES-core signals around the arbiter.
// slave = arbiter side, master = requesters/response sink/core side.
interface aes_req_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) ();
   import aes_pkg::*;

   logic [NREQ-1:0]           req_valid_i;
   logic [NREQ-1:0]           req_ready_o;
   logic [AES_BLK_W*NREQ-1:0] req_key_i;
   logic [AES_BLK_W*NREQ-1:0] req_pt_i;
   logic                      resp_valid_o;
   logic                      resp_ready_i;
   logic [IDW-1:0]            resp_id_o;
   logic [AES_BLK_W-1:0]      resp_ct_o;
   logic                      resp_err_o;
   logic                      core_start_o;
   logic [AES_BLK_W-1:0]      core_key_o;
   logic [AES_BLK_W-1:0]      core_pt_o;
   logic                      core_done_i;
   logic [AES_BLK_W-1:0]      core_ct_i;
   logic                      busy_o;

   modport slave (
      input  req_valid_i, req_key_i, req_pt_i, resp_ready_i, core_done_i, core_ct_i,
      output req_ready_o, resp_valid_o, resp_id_o, resp_ct_o, resp_err_o,
             core_start_o, core_key_o, core_pt_o, busy_o
   );

   modport master (
      output req_valid_i, req_key_i, req_pt_i, resp_ready_i, core_done_i, core_ct_i,
      input  req_ready_o, resp_valid_o, resp_id_o, resp_ct_o, resp_err_o,
             core_start_o, core_key_o, core_pt_o, busy_o
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: nearest valid requester at or after ptr, wrapping.
// Zero latency; no state, so a requester that drops valid loses nothing.
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_idx,
   output logic           gnt_any
);

   logic [IDW:0] pos;

   always_comb begin
      pos     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      // scan farthest-first so the nearest requester after ptr is the last writer
      for (int i = N - 1; i >= 0; i--) begin
         pos = {1'b0, ptr} + (IDW+1)'(i);
         if (pos >= (IDW+1)'(N)) begin
            pos = pos - (IDW+1)'(N);
         end
         if (req[pos[IDW-1:0]]) begin
            gnt_idx = pos[IDW-1:0];
            gnt_any = 1'b1;
         end
      end
      gnt = gnt_any ? (N'(1) << gnt_idx) : '0;
   end

endmodule

// File: rtl/aes_req_arbiter.sv
// Round-robin sharing of one AES128 core: accept -> start next cycle -> result 1 cycle after done.
// One job in flight; no accept until the result handshakes. AES_ARB_TIMEOUT_EN adds a BUSY watchdog.
module aes_req_arbiter import aes_pkg::*; #(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int TIMEOUT = AES_TIMEOUT_DEF
) (
   input logic              clk_i,
   input logic              rst_i,
   aes_req_arbiter_if.slave bus
);

   arb_state_t           state;
   logic [IDW-1:0]       rr_ptr;
   logic [IDW-1:0]       cur_id;
   logic [IDW-1:0]       gnt_idx;
   logic [IDW-1:0]       next_ptr;
   logic [NREQ-1:0]      gnt;
   logic                 gnt_any;
   logic                 accept;
   aes_job_t             sel_job;
   aes_job_t             job_q;
   logic [AES_BLK_W-1:0] resp_ct_q;
   logic                 resp_vld_q;
   logic                 start_q;
   logic                 busy_q;

   rr_arbiter #(.N(NREQ), .IDW(IDW)) u_rr (
      .req     (bus.req_valid_i),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   always_comb begin
      sel_job = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt_idx == IDW'(k)) begin
            sel_job.key = bus.req_key_i[k*AES_BLK_W +: AES_BLK_W];
            sel_job.pt  = bus.req_pt_i[k*AES_BLK_W +: AES_BLK_W];
         end
      end
   end

   assign accept          = (state == IDLE) && gnt_any && !rst_i;
   assign bus.req_ready_o = accept ? gnt : '0;
   assign next_ptr        = (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;

`ifdef AES_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] to_cnt;
   logic          resp_err_q;
   assign bus.resp_err_o = resp_err_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign bus.resp_err_o = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         cur_id     <= '0;
         job_q      <= '0;
         resp_ct_q  <= '0;
         resp_vld_q <= 1'b0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
         to_cnt     <= '0;
         resp_err_q <= 1'b0;
`endif
      end else begin
         start_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  job_q   <= sel_job;
                  cur_id  <= gnt_idx;
                  start_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               // the ISSUE cycle keeps a done level left over from the last job out of BUSY
`ifdef AES_ARB_TIMEOUT_EN
               to_cnt <= '0;
`endif
               state  <= BUSY;
            end
            BUSY: begin
               if (bus.core_done_i) begin
                  resp_ct_q  <= bus.core_ct_i;
                  resp_vld_q <= 1'b1;
                  state      <= RESP;
`ifdef AES_ARB_TIMEOUT_EN
                  resp_err_q <= 1'b0;
               end else if (to_cnt == CW'(TIMEOUT - 1)) begin
                  resp_ct_q  <= '0;
                  resp_vld_q <= 1'b1;
                  resp_err_q <= 1'b1;
                  state      <= RESP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
`endif
               end
            end
            RESP: begin
               if (bus.resp_ready_i) begin
                  resp_vld_q <= 1'b0;
                  busy_q     <= 1'b0;
                  rr_ptr     <= next_ptr;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.core_start_o = start_q;
   assign bus.core_key_o   = job_q.key;
   assign bus.core_pt_o    = job_q.pt;
   assign bus.resp_valid_o = resp_vld_q;
   assign bus.resp_id_o    = cur_id;
   assign bus.resp_ct_o    = resp_ct_q;
   assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Bench for aes_req_arbiter: a timestamped job model checks every cycle, directed phases pin it.
// The AES core is emulated by a latency-programmable stand-in with a known-answer vector.
module tb_aes_req_arbiter;
   import aes_pkg::*;

   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int TO   = 64;
   localparam logic [127:0] KV   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PV   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CTV  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] JUNK = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   aes_req_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   aes_req_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TO)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
      if (k == KV && p == PV) return CTV;
      return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic int pick(input logic [NREQ-1:0] v, input int p);
      for (int i = 0; i < NREQ; i++) begin
         if (v[(p + i) % NREQ]) return (p + i) % NREQ;
      end
      return -1;
   endfunction

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- AES core stand-in ----------------
   int           lat_cfg = 3;
   bit           never_done = 1'b0;
   bit           spurious = 1'b0;
   int           c_cnt = 0;
   bit           c_act = 1'b0;
   logic [127:0] c_key, c_pt, s_key, s_pt;
   logic         s_start;

   initial begin
      forever begin
         @(posedge clk);
         s_start = bus.core_start_o;
         s_key   = bus.core_key_o;
         s_pt    = bus.core_pt_o;
         #1;
         if (s_start) begin
            c_cnt = lat_cfg; c_key = s_key; c_pt = s_pt; c_act = 1'b1;
            bus.core_done_i = 1'b0;
         end else if (c_act) begin
            c_cnt--;
            bus.core_done_i = 1'b0;
            if (c_cnt == 0 && !never_done) begin
               bus.core_done_i = 1'b1;
               bus.core_ct_i   = core_fn(c_key, c_pt);
               c_act = 1'b0;
            end
         end else if (spurious) begin
            bus.core_done_i = 1'b1;
            bus.core_ct_i   = JUNK;
         end else begin
            bus.core_done_i = 1'b0;
         end
      end
   end

   // ---------------- job-level reference model + per-cycle compare ----------------
   bit           armed = 0, chk_reset = 0, in_fl = 0, resp_ph = 0, pend = 0;
   int           ptr = 0, acc = 0, id = 0, pend_cyc = 0, g, k;
   logic [127:0] key_last = '0, pt_last = '0, ct_last = '0, pend_ct = '0;
   bit           err_last = 0, pend_err = 0;
   // observations of the DUT used by the directed phases
   int           hs = 0, start_cnt = 0, start_cyc = 0, rdy_cyc = 0, rise_cyc = 0, hs_id = 0;
   logic [NREQ-1:0] rdy_vec = '0;
   logic [127:0] hs_ct = '0;
   bit           hs_err = 0, prev_valid = 0;
   int           dut_gnt[$];

   task automatic model_reset();
      in_fl = 0; resp_ph = 0; pend = 0; ptr = 0;
      key_last = '0; pt_last = '0; ct_last = '0; err_last = 0;
      chk_reset = 1;
   endtask

   always @(negedge clk) begin
      if (!armed) begin
         if (rst) begin armed = 1; model_reset(); end
      end else begin
         if (bus.core_start_o) begin start_cnt++; start_cyc = cyc; end
         if (bus.req_ready_o != '0) begin
            rdy_cyc = cyc; rdy_vec = bus.req_ready_o;
            for (int i = 0; i < NREQ; i++) if (bus.req_ready_o[i]) dut_gnt.push_back(i);
         end
         if (bus.resp_valid_o && !prev_valid) rise_cyc = cyc;
         prev_valid = bus.resp_valid_o;
         if (bus.resp_valid_o && bus.resp_ready_i && !rst) begin
            hs++; hs_ct = bus.resp_ct_o; hs_id = int'(bus.resp_id_o); hs_err = bus.resp_err_o;
         end

         if (pend && cyc == pend_cyc) begin
            pend = 0; resp_ph = 1; ct_last = pend_ct; err_last = pend_err;
         end
         if (chk_reset) begin
            chk_reset = 0;
            chk("rst_resp_valid", bus.resp_valid_o, 0);
            chk("rst_resp_id", bus.resp_id_o, 0);
            chk("rst_core_start", bus.core_start_o, 0);
            chk("rst_busy", bus.busy_o, 0);
         end
         chk("resp_ct", bus.resp_ct_o, ct_last);
         chk("resp_err", bus.resp_err_o, err_last);
         chk("core_key", bus.core_key_o, key_last);
         chk("core_pt", bus.core_pt_o, pt_last);

         if (rst) begin
            chk("ready_in_reset", bus.req_ready_o, 0);
            model_reset();
         end else if (!in_fl) begin
            g = pick(bus.req_valid_i, ptr);
            chk("req_ready", bus.req_ready_o, (g < 0) ? 0 : (1 << g));
            chk("busy_idle", bus.busy_o, 0);
            chk("valid_idle", bus.resp_valid_o, 0);
            chk("start_idle", bus.core_start_o, 0);
            if (g >= 0) begin
               in_fl = 1; acc = cyc; id = g;
               key_last = bus.req_key_i[g*128 +: 128];
               pt_last  = bus.req_pt_i[g*128 +: 128];
            end
         end else begin
            k = cyc - acc;
            chk("ready_busy", bus.req_ready_o, 0);
            chk("busy_job", bus.busy_o, 1);
            chk("core_start", bus.core_start_o, (k == 1));
            chk("resp_valid", bus.resp_valid_o, resp_ph);
            if (resp_ph) begin
               chk("resp_id", bus.resp_id_o, id);
               if (bus.resp_ready_i) begin
                  ptr = (id + 1) % NREQ; in_fl = 0; resp_ph = 0;
               end
            end else if (!pend && k >= 2) begin
               if (bus.core_done_i) begin
                  pend = 1; pend_cyc = cyc + 1; pend_ct = bus.core_ct_i; pend_err = 0;
               end
`ifdef AES_ARB_TIMEOUT_EN
               else if (k == TO + 1) begin
                  pend = 1; pend_cyc = cyc + 1; pend_ct = '0; pend_err = 1;
               end
`endif
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_job(input int r, input logic [127:0] kk, input logic [127:0] pp);
      bus.req_key_i[r*128 +: 128] = kk;
      bus.req_pt_i[r*128 +: 128]  = pp;
   endtask

   task automatic wait_start(input string name, input int budget);
      int s0 = start_cnt;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (start_cnt > s0) return;
      end
      chk({name, "_start_timeout"}, start_cnt, s0 + 1);
   endtask

   task automatic wait_hs(input string name, input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (hs >= target) return;
         tick();
      end
      chk({name, "_hs_timeout"}, hs, target);
   endtask

   task automatic wait_valid(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (bus.resp_valid_o) begin
            @(negedge clk); #1;
            return;
         end
      end
      chk({name, "_valid_timeout"}, bus.resp_valid_o, 1);
   endtask

   int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int s0, h0, sj_start;
   logic [127:0] ct0, k3, p3;
   logic [IDW-1:0] id0;

   initial begin
      bus.req_valid_i = '0; bus.req_key_i = '0; bus.req_pt_i = '0;
      bus.resp_ready_i = 1'b0; bus.core_done_i = 1'b0; bus.core_ct_i = '0;
      repeat (3) tick();
      rst = 1'b0;

      // single known-answer job on requester 1
      set_job(1, KV, PV); bus.resp_ready_i = 1'b1; lat_cfg = 4;
      s0 = start_cnt; h0 = hs;
      bus.req_valid_i = 4'b0010;
      wait_start("sj", 20);
      bus.req_valid_i = '0;
      wait_hs("sj", h0 + 1, 50);
      chk("sj_ready_vec", rdy_vec, 4'b0010);
      chk("sj_start_lat", start_cyc - rdy_cyc, 1);
      chk("sj_starts", start_cnt - s0, 1);
      chk("sj_ct", hs_ct, CTV);
      chk("sj_id", hs_id, 1);

      // fairness from a fresh reset
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      for (int r = 0; r < NREQ; r++) set_job(r, rand128(), rand128());
      dut_gnt.delete(); h0 = hs;
      bus.req_valid_i = '1;
      wait_hs("fair", h0 + 8, 400);
      bus.req_valid_i = '0;
      chk("fair_count", dut_gnt.size() >= 8, 1);
      for (int i = 0; i < 8 && i < dut_gnt.size(); i++) chk($sformatf("fair_order%0d", i), dut_gnt[i], exp_order[i]);
      tick(); tick();

      // backpressure: response held for 20 cycles with everyone requesting
      bus.resp_ready_i = 1'b0; set_job(2, rand128(), rand128());
      bus.req_valid_i = 4'b0100;
      wait_start("bp", 20);
      bus.req_valid_i = '1;
      wait_valid("bp", 50);
      ct0 = bus.resp_ct_o; id0 = bus.resp_id_o; s0 = start_cnt;
      repeat (20) tick();
      chk("bp_ct_stable", bus.resp_ct_o, ct0);
      chk("bp_id_stable", bus.resp_id_o, id0);
      chk("bp_id", id0, 2);
      chk("bp_valid_held", bus.resp_valid_o, 1);
      chk("bp_no_start", start_cnt, s0);
      h0 = hs; bus.req_valid_i = '0; bus.resp_ready_i = 1'b1;
      wait_hs("bp", h0 + 1, 10);
      tick();

      // stale done level during IDLE and ISSUE
      spurious = 1'b1; lat_cfg = 3;
      repeat (3) tick();
      k3 = rand128(); p3 = rand128(); set_job(3, k3, p3);
      h0 = hs; bus.req_valid_i = 4'b1000;
      wait_start("sp", 20);
      bus.req_valid_i = '0;
      wait_hs("sp", h0 + 1, 50);
      chk("sp_ct", hs_ct, core_fn(k3, p3));
      chk("sp_id", hs_id, 3);
      spurious = 1'b0;

      // randomized traffic
      h0 = hs;
      for (int c = 0; c < 600; c++) begin
         for (int r = 0; r < NREQ; r++) set_job(r, rand128(), rand128());
         bus.req_valid_i  = NREQ'($urandom());
         bus.resp_ready_i = ($urandom_range(0, 3) != 0);
         lat_cfg  = $urandom_range(1, 6);
         spurious = ($urandom_range(0, 7) == 0);
         tick();
      end
      bus.req_valid_i = '0; bus.resp_ready_i = 1'b1; spurious = 1'b0;
      for (int i = 0; i < 50 && bus.busy_o; i++) tick();
      chk("rnd_drained", bus.busy_o, 0);
      chk("rnd_enough_jobs", hs > h0 + 20, 1);

      // reset in the middle of BUSY
      lat_cfg = 30; set_job(2, rand128(), rand128());
      bus.req_valid_i = 4'b0100;
      wait_start("mr", 20);
      bus.req_valid_i = '0;
      repeat (5) tick();
      chk("mr_busy_before", bus.busy_o, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("mr_busy", bus.busy_o, 0);
      chk("mr_valid", bus.resp_valid_o, 0);
      h0 = hs; lat_cfg = 3; bus.req_valid_i = '1;
      wait_start("mr2", 20);
      bus.req_valid_i = '0;
      chk("mr_first_grant", rdy_vec, 4'b0001);
      wait_hs("mr2", h0 + 1, 50);
      chk("mr_resp_owner", hs_id, 0);

`ifdef AES_ARB_TIMEOUT_EN
      // watchdog: core never answers
      tick();
      never_done = 1'b1; bus.resp_ready_i = 1'b0;
      bus.req_valid_i = 4'b0010;
      wait_start("to", 20);
      bus.req_valid_i = '0;
      sj_start = start_cyc;
      wait_valid("to", 200);
      chk("to_latency", rise_cyc - sj_start, TO + 1);
      chk("to_err", bus.resp_err_o, 1);
      chk("to_ct", bus.resp_ct_o, 0);
      h0 = hs; bus.resp_ready_i = 1'b1; never_done = 1'b0;
      wait_hs("to", h0 + 1, 10);
      bus.req_valid_i = 4'b0001;
      wait_start("to2", 20);
      bus.req_valid_i = '0;
      wait_hs("to2", h0 + 2, 50);
      chk("to_err_cleared", hs_err, 0);
`endif

      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog cycles=%0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/aes_req_arbiter.md
# aes_req_arbiter

Round-robin scheduler that shares one AES128 encryption core between `NREQ` independent requesters. It accepts one {key, plaintext} job at a time from a granted requester, sequences the core through start/done, and returns the ciphertext tagged with the requester index. It sits between the bus-side request ports (AHB slaves, DMA channels) and the single AES128 instance, with the same role as the AHB interface but for multiple masters.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `IDW`, 2: requester-index width, equal to clog2(`NREQ`).
- `TIMEOUT`, 64: core watchdog limit in cycles (used only with `AES_ARB_TIMEOUT_EN`).

- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  NREQ  per-requester job valid.
- `req_ready_o`  out  NREQ  per-requester accept, one-hot or zero.
- `req_key_i`  in  128*NREQ  flattened keys; requester k is at bits [128k+127:128k].
- `req_pt_i`  in  128*NREQ  flattened plaintexts, same layout.
- `resp_valid_o`  out  1  result valid.
- `resp_ready_i`  in  1  result accept.
- `resp_id_o`  out  IDW  index of the requester that owns the result.
- `resp_ct_o`  out  128  ciphertext.
- `resp_err_o`  out  1  timeout flag; tied 0 without `AES_ARB_TIMEOUT_EN`.
- `core_start_o`  out  1  one-cycle start pulse to AES128.
- `core_key_o`  out  128  registered key to the core.
- `core_pt_o`  out  128  registered plaintext to the core.
- `core_done_i`  in  1  AES128 `data_ready_o`.
- `core_ct_i`  in  128  AES128 `ciphertext_o`.
- `busy_o`  out  1  high whenever state is not IDLE.

## Operation
- FSM states:
  - IDLE:
    - Grant goes to the lowest index ≥ `rr_ptr` with `req_valid_i` set, wrapping modulo `NREQ`.
    - `req_ready_o[g]`=1 combinationally for that index in the same cycle.
    - On that cycle, register the key and plaintext into `core_key_o`/`core_pt_o` and `g` into `cur_id`, then go to ISSUE.
    - With no valid request, stay in IDLE.
  - ISSUE: `core_start_o`=1 for exactly this cycle, then go to BUSY.
  - BUSY:
    - Wait for `core_done_i`.
    - On the first cycle `core_done_i`=1, register `core_ct_i` into `resp_ct_o`, then go to RESP.
  - RESP:
    - `resp_valid_o`=1 and `resp_id_o`=`cur_id`.
    - Hold all response outputs stable until `resp_ready_i`=1.
    - On the handshake, set `rr_ptr` to (`cur_id`+1) mod `NREQ` and go to IDLE.
- `req_ready_o` is 0 in every state except IDLE, so a new job is never accepted before the previous result is consumed.
- `core_done_i` is ignored outside BUSY, and a stale level from the previous job must not complete the new job. This holds because the ISSUE cycle separates acceptance from sampling.
- `core_key_o` and `core_pt_o` stay stable from ISSUE until the next acceptance.
- A requester that deasserts `req_valid_i` before being granted loses nothing: the arbiter has no pending state.
- Reset at any point:
  - Abandon the job in flight; its result is never presented.
  - Outputs return to their reset values, listed in Timing.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `req_ready_o`=0, `resp_valid_o`=0, `resp_id_o`=0, `resp_ct_o`=0, `resp_err_o`=0, `core_start_o`=0, `core_key_o`=0, `core_pt_o`=0, `busy_o`=0.
- Accept to start:
  - Acceptance in cycle N; `core_start_o` high in cycle N+1.
  - `resp_valid_o` rises 1 cycle after the first `core_done_i` in BUSY.
- Minimum spacing between accepts is core latency + 3 cycles when `resp_ready_i` is held high.
- After the RESP handshake in cycle M, the next accept can happen in cycle M+1.
- In the first cycle after reset, `rr_ptr`=0, so requester 0 has priority.

## Configuration
- Macro: `AES_ARB_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches `TIMEOUT` without `core_done_i`, go to RESP with `resp_err_o`=1 and `resp_ct_o`=0.
  - `resp_err_o` clears when the next response is presented without error.
- Undefined: no counter; BUSY waits indefinitely and `resp_err_o` is tied 0.

## Structure
- Shared package `aes_pkg` holds:
  - the FSM state enum (IDLE, ISSUE, BUSY, RESP);
  - the `AES_BLK_W`=128 constant;
  - the default `TIMEOUT`.
- Sub-module `rr_arbiter`: combinational round-robin grant from `req_valid_i` and `rr_ptr`, producing one-hot grant plus index. It is reused by other shared-resource controllers.

## Test plan
- Single job:
  - Stimulus: req 1 valid with key 000102…0f, pt 00112233445566778899aabbccddeeff, `resp_ready_i` held high.
  - Required: one `core_start_o` pulse one cycle after `req_ready_o[1]`; response ct 69c4e0d86a7b0430d8cdb78070b4c55a with `resp_id_o`=1.
- Fairness:
  - Stimulus: all 4 requesters held valid for 8 jobs.
  - Required: grant order 0,1,2,3,0,1,2,3.
- Backpressure:
  - Stimulus: `resp_ready_i` held 0 for 20 cycles after `resp_valid_o` rises.
  - Required: `resp_ct_o`/`resp_id_o` stable, all `req_ready_o`=0, no `core_start_o`.
- Spurious done: `core_done_i` high during IDLE and ISSUE → no state change; the result is taken only from BUSY.
- Reset mid-job: assert `rst_i` in BUSY → next cycle all outputs at reset values, `rr_ptr`=0, no response emitted.
- Timeout (`AES_ARB_TIMEOUT_EN`, `TIMEOUT`=64):
  - Stimulus: core never asserts done.
  - Required: `resp_valid_o` with `resp_err_o`=1 exactly 64 BUSY cycles after ISSUE; `resp_ct_o`=0.
